telemetry_sampler: RTL and testbench
====================================

// Module: telemetry_sampler
// PURPOSE
//   Upstream stage of the telemetry overlay. Produces the telemetry_values[] array that the overlay renders.
//   Each channel is either LEVEL (snapshot of a live value) or RATE (event pulses counted over a window of frames).
//   Outputs change only on a frame boundary, so the displayed digits never tear mid-frame.
//   Sits between the game/SPI logic and the telemetry overlay, in the VGA clock domain.
// PARAMETERS
//   NUM_SIGNALS    7       number of telemetry channels (rows on screen)
//   VALUE_WIDTH    9       width of every channel value and accumulator
//   WINDOW_FRAMES  60      frames per RATE window (>=1); 60 gives per-second rates at 60 Hz
//   RATE_MASK      '0      NUM_SIGNALS-bit mask; bit s=1 makes channel s RATE, bit s=0 makes it LEVEL
// PORTS
//   clk               in   1                         VGA pixel clock
//   reset             in   1                         synchronous, active-high
//   frame_start       in   1                         1-cycle pulse at start of each frame (from VGA controller)
//   freeze            in   1                         1: hold all displayed values (accumulators still run)
//   level_values      in   [VALUE_WIDTH-1:0] x NUM_SIGNALS   live values; used by LEVEL channels only
//   event_pulses      in   NUM_SIGNALS               per-channel event strobes; used by RATE channels only
//   telemetry_values  out  [VALUE_WIDTH-1:0] x NUM_SIGNALS   registered; drives the overlay
//   window_done       out  1                         1-cycle pulse when a RATE window closes
// BEHAVIOUR
//   Reset (sync): telemetry_values all 0; window_done=0; win_cnt=0; all accumulators 0.
//     Reset asserted mid-window discards partial counts.
//   Window counter win_cnt, range 0..WINDOW_FRAMES-1:
//     - Increments on each frame_start; wraps to 0.
//     - win_end = frame_start && win_cnt==WINDOW_FRAMES-1.
//     - window_done is registered from win_end, so it is high the cycle after win_end.
//   LEVEL channel s:
//     - On frame_start && !freeze: telemetry_values[s] <= level_values[s], sampled that same cycle.
//     - Otherwise it holds. Latency is 1 clk from frame_start.
//   RATE channel s, accumulator acc[s] (VALUE_WIDTH bits):
//     - event_pulses[s] increments acc by 1 and saturates at 2^VALUE_WIDTH-1. There is no wrap.
//     - On win_end:
//         - If !freeze: telemetry_values[s] <= acc[s] + event_pulses[s] (saturated).
//         - Always: acc[s] <= 0, so no carry into the next window.
//       A pulse coincident with win_end is counted in the closing window.
//     - A pulse while freeze=1 is still counted.
//   freeze:
//     - Blocks output updates only; it is level sensitive.
//     - Deassertion takes effect at the next frame_start (LEVEL) or the next win_end (RATE).
//   WINDOW_FRAMES==1: win_end == frame_start, so the rate is events per frame.
//   frame_start pulses on consecutive cycles: each pulse is honoured (win_cnt advances every pulse).
//   No combinational path from any input to telemetry_values.
// STRUCTURE
//   telemetry_pkg:
//     - typedef enum logic {TLM_LEVEL, TLM_RATE} tlm_mode_e
//     - function sat_inc(value, width) returning the saturated +1
//   Sub-module telemetry_rate_counter: one per RATE channel (generate over RATE_MASK).
//     - Ports: clk, reset, event_pulse, win_end, freeze, count_out.
//     - Holds acc plus the saturating/close logic.
//   Top: win_cnt, window_done, LEVEL snapshot regs, generate loop. Output array feeds the overlay unchanged.
// TESTING
//   1. Reset, then frame_start with level_values[0]=123
//      -> telemetry_values[0]=123 one clk later; stays 0 before that.
//   2. RATE ch1, WINDOW_FRAMES=4, 37 pulses across 4 frames
//      -> value 37 at the 4th frame_start+1; window_done pulses once; next window starts at 0.
//   3. VALUE_WIDTH=9, 600 pulses in one window
//      -> output 511 (saturated); next window with 5 pulses -> 5.
//   4. Pulse on ch1 in the same cycle as win_end with 9 earlier pulses
//      -> output 10; the following window begins at 0.
//   5. freeze=1 across a win_end with 20 pulses
//      -> output keeps its old value; LEVEL channels ignore frame_start.
//      Release freeze -> updates at the next boundary.
//   6. Assert reset mid-window after 15 pulses
//      -> all outputs 0 next clk; win_cnt=0; next window counts from 0.

Source files
------------

// File: rtl/telemetry_pkg.sv
// Shared types and helpers for the telemetry sampler: channel mode encoding
// and the saturating increment used by RATE accumulators.
package telemetry_pkg;

    typedef enum logic {TLM_LEVEL, TLM_RATE} tlm_mode_e;

    // Returns value+1, clamped at the all-ones value of a width-bit field.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_v;
        max_v = (32'd1 << width) - 32'd1;
        return (value >= max_v) ? max_v : value + 32'd1;
    endfunction

endpackage

// File: rtl/telemetry_rate_counter.sv
// One RATE channel: counts event pulses over a window and publishes the
// saturated total when the window closes, unless the display is frozen.
module telemetry_rate_counter
    import telemetry_pkg::*;
#(
    parameter int VALUE_WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   event_pulse,
    input  logic                   win_end,
    input  logic                   freeze,
    output logic [VALUE_WIDTH-1:0] count_out
);

    logic [VALUE_WIDTH-1:0] acc_q, acc_d;
    logic [VALUE_WIDTH-1:0] count_q, count_d;
    logic [VALUE_WIDTH-1:0] acc_inc;
    logic [VALUE_WIDTH-1:0] closing;

    always_comb begin
        acc_inc = VALUE_WIDTH'(sat_inc(32'(acc_q), VALUE_WIDTH));
        // A pulse landing on the closing cycle belongs to the closing window.
        closing = event_pulse ? acc_inc : acc_q;
        acc_d   = acc_q;
        count_d = count_q;
        if (win_end) begin
            acc_d = '0;
            if (!freeze) begin
                count_d = closing;
            end
        end else if (event_pulse) begin
            acc_d = acc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/telemetry_sampler.sv
// Frame-synchronous telemetry sampler: LEVEL channels snapshot live values on
// frame_start, RATE channels report event counts per window of frames.
module telemetry_sampler
    import telemetry_pkg::*;
#(
    parameter int                     NUM_SIGNALS   = 7,
    parameter int                     VALUE_WIDTH   = 9,
    parameter int                     WINDOW_FRAMES = 60,
    parameter logic [NUM_SIGNALS-1:0] RATE_MASK     = '0
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    frame_start,
    input  logic                                    freeze,
    input  logic [NUM_SIGNALS-1:0][VALUE_WIDTH-1:0] level_values,
    input  logic [NUM_SIGNALS-1:0]                  event_pulses,
    output logic [NUM_SIGNALS-1:0][VALUE_WIDTH-1:0] telemetry_values,
    output logic                                    window_done
);

    localparam int CNT_W = (WINDOW_FRAMES > 1) ? $clog2(WINDOW_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_FRAMES - 1);

    logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic             window_done_q;
    logic             win_end;

    assign win_end = frame_start && (win_cnt_q == CNT_LAST);

    always_comb begin
        win_cnt_d = win_cnt_q;
        if (frame_start) begin
            win_cnt_d = win_end ? '0 : win_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt_q     <= '0;
            window_done_q <= 1'b0;
        end else begin
            win_cnt_q     <= win_cnt_d;
            window_done_q <= win_end;
        end
    end

    assign window_done = window_done_q;

    for (genvar s = 0; s < NUM_SIGNALS; s++) begin : g_ch
        localparam tlm_mode_e MODE = RATE_MASK[s] ? TLM_RATE : TLM_LEVEL;

        if (MODE == TLM_RATE) begin : g_rate
            logic unused_level;
            assign unused_level = ^level_values[s];

            telemetry_rate_counter #(
                .VALUE_WIDTH (VALUE_WIDTH)
            ) u_rate (
                .clk         (clk),
                .reset       (reset),
                .event_pulse (event_pulses[s]),
                .win_end     (win_end),
                .freeze      (freeze),
                .count_out   (telemetry_values[s])
            );
        end else begin : g_level
            logic                   unused_evt;
            logic [VALUE_WIDTH-1:0] level_q, level_d;

            assign unused_evt = event_pulses[s];

            always_comb begin
                level_d = level_q;
                if (frame_start && !freeze) begin
                    level_d = level_values[s];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    level_q <= '0;
                end else begin
                    level_q <= level_d;
                end
            end

            assign telemetry_values[s] = level_q;
        end
    end

endmodule

// File: tb/tb_telemetry_sampler.sv
// Directed bench for telemetry_sampler: ch1 is RATE with a 4-frame window,
// all other channels are LEVEL.
module tb_telemetry_sampler;

    localparam int NS = 7;
    localparam int VW = 9;
    localparam int WF = 4;

    logic                   clk;
    logic                   reset;
    logic                   frame_start;
    logic                   freeze;
    logic [NS-1:0][VW-1:0]  level_values;
    logic [NS-1:0]          event_pulses;
    logic [NS-1:0][VW-1:0]  telemetry_values;
    logic                   window_done;

    int n_checks = 0;
    int n_errors = 0;

    telemetry_sampler #(
        .NUM_SIGNALS   (NS),
        .VALUE_WIDTH   (VW),
        .WINDOW_FRAMES (WF),
        .RATE_MASK     (7'b000_0010)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .frame_start      (frame_start),
        .freeze           (freeze),
        .level_values     (level_values),
        .event_pulses     (event_pulses),
        .telemetry_values (telemetry_values),
        .window_done      (window_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        frame_start  = 1'b0;
        event_pulses = '0;
        tick();
        reset = 1'b0;
    endtask

    // One frame_start cycle, optionally with a coincident ch1 pulse.
    task automatic fs(input bit ev);
        frame_start     = 1'b1;
        event_pulses[1] = ev;
        tick();
        frame_start  = 1'b0;
        event_pulses = '0;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            event_pulses[1] = 1'b1;
            tick();
        end
        event_pulses = '0;
    endtask

    initial begin
        reset        = 1'b1;
        frame_start  = 1'b0;
        freeze       = 1'b0;
        level_values = '0;
        event_pulses = '0;
        tick();

        // 1. reset values, LEVEL snapshot with 1-clk latency
        do_reset();
        check("rst_ch0", 32'(telemetry_values[0]), 0);
        check("rst_ch1", 32'(telemetry_values[1]), 0);
        check("rst_ch3", 32'(telemetry_values[3]), 0);
        check("rst_wdone", 32'(window_done), 0);
        level_values[0] = 9'd123;
        level_values[3] = 9'h1FF;
        frame_start     = 1'b1;
        check("lvl_before_edge", 32'(telemetry_values[0]), 0);
        tick();
        frame_start = 1'b0;
        check("lvl_ch0", 32'(telemetry_values[0]), 123);
        check("lvl_ch3", 32'(telemetry_values[3]), 511);
        level_values[0] = 9'd5;
        tick();
        check("lvl_hold", 32'(telemetry_values[0]), 123);
        level_values[0] = 9'd123;

        // 2. 37 pulses across a 4-frame window
        do_reset();
        fs(0); pulses(10);
        fs(0); pulses(10);
        fs(0); pulses(17);
        check("rate_pre_close", 32'(telemetry_values[1]), 0);
        fs(0);
        check("rate_37", 32'(telemetry_values[1]), 37);
        check("wdone_high", 32'(window_done), 1);
        tick();
        check("wdone_low", 32'(window_done), 0);
        fs(0);
        check("wdone_not_again", 32'(window_done), 0);
        fs(0); fs(0); pulses(3); fs(0);
        check("rate_next_3", 32'(telemetry_values[1]), 3);

        // 3. saturation, then recovery
        fs(0); pulses(600); fs(0); fs(0); fs(0);
        check("rate_sat", 32'(telemetry_values[1]), 511);
        fs(0); pulses(5); fs(0); fs(0); fs(0);
        check("rate_after_sat", 32'(telemetry_values[1]), 5);

        // 4. pulse coincident with window close
        fs(0); pulses(9); fs(0); fs(0); fs(1);
        check("rate_coincident", 32'(telemetry_values[1]), 10);
        fs(0); pulses(2); fs(0); fs(0); fs(0);
        check("rate_after_coinc", 32'(telemetry_values[1]), 2);

        // 5. freeze across a window close
        freeze          = 1'b1;
        level_values[0] = 9'd200;
        fs(0); pulses(20); fs(0); fs(0); fs(0);
        check("frz_rate_hold", 32'(telemetry_values[1]), 2);
        check("frz_lvl_hold", 32'(telemetry_values[0]), 123);
        freeze = 1'b0;
        tick();
        check("unfrz_no_boundary", 32'(telemetry_values[0]), 123);
        fs(0);
        check("unfrz_lvl", 32'(telemetry_values[0]), 200);
        check("unfrz_rate_wait", 32'(telemetry_values[1]), 2);
        pulses(4); fs(0); fs(0); fs(0);
        check("unfrz_rate", 32'(telemetry_values[1]), 4);
        fs(0);
        freeze = 1'b1;
        pulses(6);
        freeze = 1'b0;
        fs(0); fs(0); fs(0);
        check("frz_pulses_counted", 32'(telemetry_values[1]), 6);

        // 6. reset mid-window discards partial counts and restarts win_cnt
        fs(0); pulses(15);
        do_reset();
        check("mid_rst_ch0", 32'(telemetry_values[0]), 0);
        check("mid_rst_ch1", 32'(telemetry_values[1]), 0);
        check("mid_rst_wdone", 32'(window_done), 0);
        fs(0); pulses(3); fs(0); fs(0);
        check("mid_rst_no_early", 32'(window_done), 0);
        fs(0);
        check("mid_rst_rate", 32'(telemetry_values[1]), 3);
        check("mid_rst_wdone2", 32'(window_done), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
